// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and constants for the two-requester memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int unsigned c_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Brief    : Combinational winner selection. Define ARB_RR_EN for round-robin
//            on simultaneous requests; otherwise D has fixed priority over I.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick
    import arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t i_lastServed,
    output owner_t o_grant
);

`ifdef ARB_RR_EN
    always_comb begin
        o_grant = OWN_I;
        if (i_req && d_req) begin
            // the side that was not served last takes the tie
            o_grant = (i_lastServed == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            o_grant = OWN_D;
        end
    end
`else
    logic w_unusedPickIn;
    assign w_unusedPickIn = i_req ^ i_lastServed;

    always_comb begin
        o_grant = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates an I-fetch and a D load/store port onto one memory
//            port with MEM_LAT-cycle access. ARB_RR_EN selects round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          arb_busy,
    output logic          arb_owner
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

    state_t               r_state;
    state_t               w_nextState;
    owner_t               r_owner;
    owner_t               w_grant;
    owner_t               w_lastServed;
    logic                 w_anyReq;
    logic                 r_we;
    logic [AW-1:0]        r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_iRdata;
    logic [31:0]          r_dRdata;
    logic [c_CNT_W-1:0]   r_cnt;

    assign w_anyReq = i_req | d_req;

`ifdef ARB_RR_EN
    owner_t r_lastServed;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_lastServed <= OWN_I;
        end else if (r_state == IDLE && w_anyReq) begin
            r_lastServed <= w_grant;
        end
    end

    assign w_lastServed = r_lastServed;
`else
    assign w_lastServed = OWN_I;
`endif

    arb_pick u_pick (
        .i_req        (i_req),
        .d_req        (d_req),
        .i_lastServed (w_lastServed),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        arb_busy    = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                arb_busy = 1'b1;
                mem_re   = ~r_we;
                mem_we   = r_we;
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                arb_busy    = 1'b1;
                i_ack       = (r_owner == OWN_I);
                d_ack       = (r_owner == OWN_D);
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request inputs are sampled only in IDLE; later changes are ignored.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_owner  <= OWN_I;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_iRdata <= '0;
            r_dRdata <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_grant;
                        r_addr  <= (w_grant == OWN_D) ? d_addr : i_addr;
                        r_wdata <= (w_grant == OWN_D) ? d_wdata : 32'd0;
                        r_we    <= (w_grant == OWN_D) & d_we;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner == OWN_D) begin
                                r_dRdata <= mem_rdata;
                            end else begin
                                r_iRdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign arb_owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter; instance A uses MEM_LAT=1,
//            instance B uses MEM_LAT=3. Build with ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset_n, i_req, d_req, d_we, sel;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        aIAck, aDAck, aRe, aWe, aBusy, aOwner;
    logic [31:0] aIRd, aDRd, aAddr, aWdata, aMemRd;
    logic        bIAck, bDAck, bRe, bWe, bBusy, bOwner;
    logic [31:0] bIRd, bDRd, bAddr, bWdata, bMemRd;

    // Memory model: fixed opcode at 0x10, tagged address elsewhere.
    function automatic logic [31:0] memModel(input logic [31:0] a);
        return (a == 32'h10) ? 32'h00500093 : {16'hC0DE, a[15:0]};
    endfunction

    assign aMemRd = memModel(aAddr);
    assign bMemRd = memModel(bAddr);

    mem_arbiter #(.MEM_LAT(LAT_A), .AW(32)) dutA (
        .clk(clk), .Reset_n(Reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(aIAck), .i_rdata(aIRd),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(aDAck), .d_rdata(aDRd),
        .mem_addr(aAddr), .mem_wdata(aWdata), .mem_re(aRe), .mem_we(aWe),
        .mem_rdata(aMemRd), .arb_busy(aBusy), .arb_owner(aOwner)
    );

    mem_arbiter #(.MEM_LAT(LAT_B), .AW(32)) dutB (
        .clk(clk), .Reset_n(Reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(bIAck), .i_rdata(bIRd),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(bDAck), .d_rdata(bDRd),
        .mem_addr(bAddr), .mem_wdata(bWdata), .mem_re(bRe), .mem_we(bWe),
        .mem_rdata(bMemRd), .arb_busy(bBusy), .arb_owner(bOwner)
    );

    logic        mIAck, mDAck, mRe, mWe, mBusy, mOwner;
    logic [31:0] mIRd, mDRd, mAddr, mWdata;
    assign mIAck  = sel ? bIAck  : aIAck;
    assign mDAck  = sel ? bDAck  : aDAck;
    assign mRe    = sel ? bRe    : aRe;
    assign mWe    = sel ? bWe    : aWe;
    assign mBusy  = sel ? bBusy  : aBusy;
    assign mOwner = sel ? bOwner : aOwner;
    assign mIRd   = sel ? bIRd   : aIRd;
    assign mDRd   = sel ? bDRd   : aDRd;
    assign mAddr  = sel ? bAddr  : aAddr;
    assign mWdata = sel ? bWdata : aWdata;

    typedef struct {
        bit          own;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackCyc;
    } exp_t;

    exp_t expQ[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   busyLow = 0;
    int   accCnt  = 0;
    logic [31:0] shI = '0;
    logic [31:0] shD = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic pushExp(input bit own, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int ackCyc);
        exp_t e;
        e.own = own; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.ackCyc = ackCyc;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        Reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        tick(2);
        Reset_n = 1'b1;
    endtask

    task automatic waitAck(input bit wantD);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(1);
            if (!mBusy) busyLow++;
            if (wantD ? mDAck : mIAck) found = 1'b1;
        end
        if (wantD) chk("wait_d_ack", {31'b0, found}, 32'd1);
        else       chk("wait_i_ack", {31'b0, found}, 32'd1);
    endtask

    // Monitor: checks every memory access and every ack against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!Reset_n) begin
            expQ.delete();
            accCnt = 0;
            shI = '0;
            shD = '0;
        end else begin
            if (mRe || mWe) begin
                if (expQ.size() == 0) begin
                    chk("access_unexpected", {31'b0, mRe | mWe}, 32'd0);
                end else begin
                    e = expQ[0];
                    chk("mem_re_we_excl", {31'b0, mRe & mWe}, 32'd0);
                    chk("access_dir_we", {31'b0, mWe}, {31'b0, e.we});
                    chk("mem_addr", mAddr, e.addr);
                    chk("arb_owner", {31'b0, mOwner}, {31'b0, e.own});
                    if (e.we) chk("mem_wdata", mWdata, e.wdata);
                    accCnt++;
                end
            end
            if (mIAck || mDAck) begin
                if (expQ.size() == 0) begin
                    chk("ack_unexpected", {31'b0, mIAck | mDAck}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("ack_onehot", {31'b0, mIAck & mDAck}, 32'd0);
                    chk("ack_owner", {31'b0, mDAck}, {31'b0, e.own});
                    chk("ack_cycle", cyc, e.ackCyc);
                    chk("access_cycles", accCnt, sel ? LAT_B : LAT_A);
                    if (!e.we) begin
                        if (e.own) shD = e.rdata;
                        else       shI = e.rdata;
                    end
                    chk("i_rdata", mIRd, shI);
                    chk("d_rdata", mDRd, shD);
                end
                accCnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        sel = 1'b0;
        doReset();
        Reset_n = 1'b0;
        tick(1);
        // reset state of both instances
        chk("rst_busy_b",   {31'b0, bBusy},  32'd0);
        chk("rst_owner_b",  {31'b0, bOwner}, 32'd0);
        chk("rst_re_we_b",  {30'b0, bRe, bWe}, 32'd0);
        chk("rst_acks_b",   {30'b0, bIAck, bDAck}, 32'd0);
        chk("rst_addr_b",   bAddr,  32'd0);
        chk("rst_wdata_b",  bWdata, 32'd0);
        chk("rst_irdata_b", bIRd,   32'd0);
        chk("rst_drdata_b", bDRd,   32'd0);
        chk("rst_busy_a",   {31'b0, aBusy},  32'd0);
        chk("rst_re_we_a",  {30'b0, aRe, aWe}, 32'd0);

        // I read, MEM_LAT=1: ack in cycle 3 counting the request cycle
        Reset_n = 1'b1;
        c0 = cyc;
        i_addr = 32'h10; i_req = 1'b1;
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 2);
        waitAck(1'b0);
        i_req = 1'b0;

        sel = 1'b1;
        doReset();

        // D write, MEM_LAT=3: mem_we for 3 cycles, ack in cycle 5
        tick(2);
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        pushExp(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, c0 + 4);
        waitAck(1'b1);
        d_req = 1'b0; d_we = 1'b0;

        // D read with the address changed after the grant
        tick(2);
        c0 = cyc;
        d_req = 1'b1; d_addr = 32'h40;
        pushExp(1'b1, 1'b0, 32'h40, 32'h0, 32'hC0DE0040, c0 + 4);
        tick(1);
        d_addr = 32'h80;
        waitAck(1'b1);
        d_req = 1'b0;

        // simultaneous requests from a fresh last-served state
        doReset();
        c0 = cyc;
        i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
`ifdef ARB_RR_EN
        pushExp(1'b1, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, c0 + 4);
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 9);
        pushExp(1'b1, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, c0 + 14);
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 19);
        waitAck(1'b1);
        waitAck(1'b0);
        waitAck(1'b1);
        waitAck(1'b0);
        i_req = 1'b0; d_req = 1'b0;
`else
        pushExp(1'b1, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, c0 + 4);
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 9);
        waitAck(1'b1);
        d_req = 1'b0;
        waitAck(1'b0);
        i_req = 1'b0;
`endif

        // i_req held: acks every 5 cycles, one idle cycle between them
        tick(2);
        c0 = cyc;
        i_addr = 32'h10; i_req = 1'b1;
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 4);
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 9);
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, c0 + 14);
        waitAck(1'b0);
        busyLow = 0;
        waitAck(1'b0);
        waitAck(1'b0);
        i_req = 1'b0;
        chk("busy_low_gap", busyLow, 32'd2);

        // reset in the second ACCESS cycle of a write aborts it
        tick(2);
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        pushExp(1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0, c0 + 4);
        tick(2);
        chk("abort_we_active", {31'b0, mWe}, 32'd1);
        Reset_n = 1'b0;
        tick(1);
        chk("abort_we_low",   {31'b0, mWe},   32'd0);
        chk("abort_re_low",   {31'b0, mRe},   32'd0);
        chk("abort_busy",     {31'b0, mBusy}, 32'd0);
        chk("abort_owner",    {31'b0, mOwner}, 32'd0);
        chk("abort_d_ack",    {31'b0, mDAck}, 32'd0);
        chk("abort_addr",     mAddr,  32'd0);
        chk("abort_wdata",    mWdata, 32'd0);
        chk("abort_i_rdata",  mIRd,   32'd0);
        chk("abort_d_rdata",  mDRd,   32'd0);
        d_req = 1'b0; d_we = 1'b0;
        Reset_n = 1'b1;
        tick(3);
        chk("abort_still_idle", {31'b0, mBusy}, 32'd0);

        // requester re-issues the write
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1;
        pushExp(1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0, c0 + 4);
        waitAck(1'b1);
        d_req = 1'b0; d_we = 1'b0;

        tick(3);
        chk("queue_empty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read/write latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on posedge clk.
REQ-004 SHALL have port Reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports i_req (in, 1), i_addr (in, AW), i_ack (out, 1), i_rdata (out, 32): the instruction-fetch requester.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, AW), d_wdata (in, 32), d_ack (out, 1), d_rdata (out, 32): the load/store requester.
REQ-007 SHALL have ports mem_addr (out, AW), mem_wdata (out, 32), mem_re (out, 1), mem_we (out, 1), mem_rdata (in, 32): the single shared memory port.
REQ-008 SHALL have ports arb_busy (out, 1) and arb_owner (out, 1; 0=I, 1=D): status outputs.

Function
REQ-009 SHALL implement the states IDLE, ACCESS and DONE.
REQ-010 IDLE: if any req is sampled high, SHALL latch the winner's addr, wdata and we, set arb_owner, load the latency counter with MEM_LAT-1, and enter ACCESS; otherwise SHALL remain in IDLE.
REQ-011 ACCESS: SHALL drive mem_addr and mem_wdata from the latched values, and SHALL hold mem_re=~we or mem_we=we high for every ACCESS cycle.
REQ-012 ACCESS: SHALL decrement the counter each cycle; at count 0 SHALL capture mem_rdata into the winner's rdata register and enter DONE.
REQ-013 DONE: SHALL pulse the winner's ack for exactly one cycle, drop mem_re/mem_we, and return to IDLE.
REQ-014 Latency SHALL be MEM_LAT+2 cycles from the edge sampling req to the cycle where ack is high.
REQ-015 A requester SHALL hold req and its inputs stable until ack; inputs are sampled only in IDLE, so changes after the grant are ignored.
REQ-016 If req is still high in the IDLE cycle following ack, that requester SHALL be treated as making a new request.
REQ-017 If both reqs are high in IDLE, fixed priority SHALL grant d first, unless REQ-024 applies.
REQ-018 The losing requester's ack SHALL stay low, and its rdata SHALL be unchanged.
REQ-019 For a write, rdata SHALL be left unchanged and ack SHALL still pulse.
REQ-020 arb_busy SHALL be high in ACCESS and DONE and low in IDLE.
REQ-021 mem_re and mem_we SHALL never be high simultaneously and SHALL never be high outside ACCESS.

Reset
REQ-022 When Reset_n=0 at a clock edge: state SHALL be IDLE; i_ack, d_ack, mem_re, mem_we, arb_busy and arb_owner SHALL be 0; mem_addr, mem_wdata, i_rdata and d_rdata SHALL be 0; the counter SHALL be 0.
REQ-023 Reset asserted mid-ACCESS or mid-DONE SHALL abort the transfer, with no ack issued and mem_we low from the next cycle; the requester SHALL re-request.

Configuration
REQ-024 With ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not served last wins, and the last-served flag resets to I so D wins first. Without ARB_RR_EN, fixed d-over-i priority SHALL apply and no last-served flag SHALL exist.

Structure
REQ-025 Package arb_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the owner enum (OWN_I/OWN_D), and the counter width constant (4).
REQ-026 Winner selection SHALL be a combinational sub-module arb_pick (inputs i_req, d_req, last-served flag; output grant id), and the ARB_RR_EN option SHALL live inside it.

Verification
REQ-027 I read: MEM_LAT=1, i_req=1, i_addr=0x10, mem returns 0x00500093 -> mem_re high for 1 cycle, i_ack at cycle 3, i_rdata=0x00500093.
REQ-028 D write: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, MEM_LAT=3 -> mem_we high for 3 cycles with addr 0x40, d_ack at cycle 5, mem_re never high.
REQ-029 Simultaneous i_req and d_req, both held -> fixed priority: D acked first, then I; ARB_RR_EN build: D, I, D, I alternating over 4 grants.
REQ-030 Reset_n=0 in the second ACCESS cycle of a MEM_LAT=3 write -> mem_we low next cycle, no d_ack, all outputs 0, IDLE.
REQ-031 d_addr changed from 0x40 to 0x80 during ACCESS -> mem_addr stays 0x40 through the transfer.
REQ-032 i_req held high continuously -> back-to-back acks every MEM_LAT+2 cycles, arb_busy low for exactly one cycle between them.
